// File: rtl/wb_merge_stage.sv
// wb_merge_stage: merges 1-cycle ALU results and FIFO-buffered load responses onto one register-file write port.
// Latency: ALU accepted in cycle N -> write in N+1; load pushed into an idle, empty FIFO -> write in N+2.
// Backpressure: mem_ready drops only when the FIFO is full; a full FIFO drains first and holds off the ALU (alu_ready=0).
//
// Ports:
//   clk, rst                           clock (rising edge), synchronous active-high reset
//   alu_valid/alu_ready/alu_addr/alu_data  ALU result handshake (alu_ready is combinational)
//   mem_valid/mem_ready/mem_addr/mem_data  load response handshake into the FIFO (mem_ready is combinational)
//   we, wr_addr, wr_data               registered register-file write port
//   drop                               registered one-cycle pulse: selected write targeted an unimplemented register
//   fifo_count                         registered load FIFO occupancy

// wb_fifo: generic single-clock FIFO with registered occupancy count.
// Latency: an entry pushed in cycle N is visible at the head in cycle N+1 (no bypass).
// Backpressure: none internally; the caller must not push when count == DEPTH or pop when empty.
module wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;

   // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_data;
   end

   assign pop_data = mem[rptr];
endmodule

module wb_merge_stage #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 4,
   parameter int NUM_REGS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [3:0]              alu_addr,
   input  logic [WIDTH-1:0]        alu_data,
   input  logic                    mem_valid,
   output logic                    mem_ready,
   input  logic [3:0]              mem_addr,
   input  logic [WIDTH-1:0]        mem_data,
   output logic                    we,
   output logic [3:0]              wr_addr,
   output logic [WIDTH-1:0]        wr_data,
   output logic                    drop,
   output logic [$clog2(DEPTH):0]  fifo_count
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [3:0]       addr;
      logic [WIDTH-1:0] data;
   } result_t;

   result_t push_ent;
   result_t head;
   result_t sel;
   logic    full;
   logic    nonempty;
   logic    push;
   logic    pop;
   logic    sel_any;
   logic    in_range;

   wb_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_ent),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count)
   );

   // Arbitration: a full FIFO always wins so loads can never deadlock behind
   // a continuous ALU stream; otherwise the ALU has priority over buffered loads.
   always_comb begin
      full      = (fifo_count == CW'(DEPTH));
      nonempty  = (fifo_count != '0);
      alu_ready = !full;
      // Readiness ignores a same-cycle pop: no full pass-through.
      mem_ready = !full;
      push      = mem_valid && mem_ready;
      push_ent  = '{addr: mem_addr, data: mem_data};
      pop       = full || (!alu_valid && nonempty);
      sel_any   = pop || alu_valid;
      sel       = pop ? head : '{addr: alu_addr, data: alu_data};
      in_range  = 32'(sel.addr) < NUM_REGS;
   end

   // Out-of-range writes still load wr_addr/wr_data so the dropped target is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         we      <= 1'b0;
         drop    <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (sel_any) begin
         we      <= in_range;
         drop    <= !in_range;
         wr_addr <= sel.addr;
         wr_data <= sel.data;
      end else begin
         we      <= 1'b0;
         drop    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wb_merge_stage.sv
// tb_wb_merge_stage: randomized and directed stimulus against a queue-based reference model of wb_merge_stage.
// Latency: model state advances on the same rising edge as the DUT; outputs are sampled 1-3 time units after edges.
// Backpressure: the model applies the ready rules itself; stimulus may offer loads while the FIFO is full.
module tb_wb_merge_stage;
   localparam int WIDTH    = 32;
   localparam int DEPTH    = 4;
   localparam int NUM_REGS = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             alu_valid;
   logic             alu_ready;
   logic [3:0]       alu_addr;
   logic [WIDTH-1:0] alu_data;
   logic             mem_valid;
   logic             mem_ready;
   logic [3:0]       mem_addr;
   logic [WIDTH-1:0] mem_data;
   logic             we;
   logic [3:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             drop;
   logic [2:0]       fifo_count;

   wb_merge_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .drop(drop), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: buffered loads as a plain queue of {addr, data}.
   logic [35:0] m_q[$];
   logic        m_we = 1'b0;
   logic        m_drop = 1'b0;
   logic [3:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   logic [35:0] wlog[$];     // every write the DUT performed, in order
   logic [1:0]  obs_comb, exp_comb;
   int          max_cnt;

   wire  [40:0] dut_vec = {we, drop, wr_addr, wr_data, fifo_count};
   logic [40:0] mdl_vec;
   always_comb mdl_vec = {m_we, m_drop, m_addr, m_data, 3'(m_q.size())};

   // One clock: samples combinational readys against the model, then advances model and DUT together.
   task automatic cyc();
      logic [35:0] sel;
      bit          have, push_ok;
      logic        n_we, n_drop;
      logic [3:0]  n_addr;
      logic [31:0] n_data;
      #2;
      obs_comb = {alu_ready, mem_ready};
      exp_comb = {m_q.size() != DEPTH, m_q.size() < DEPTH};
      push_ok  = mem_valid && (m_q.size() < DEPTH);
      have     = 1'b0;
      sel      = '0;
      if (m_q.size() == DEPTH) begin
         sel = m_q.pop_front(); have = 1'b1;
      end else if (alu_valid) begin
         sel = {alu_addr, alu_data}; have = 1'b1;
      end else if (m_q.size() != 0) begin
         sel = m_q.pop_front(); have = 1'b1;
      end
      if (push_ok) m_q.push_back({mem_addr, mem_data});
      n_addr = m_addr; n_data = m_data; n_we = 1'b0; n_drop = 1'b0;
      if (have) begin
         n_addr = sel[35:32];
         n_data = sel[31:0];
         n_we   = (int'(sel[35:32]) < NUM_REGS);
         n_drop = !n_we;
      end
      if (rst) begin
         m_q.delete();
         n_we = 1'b0; n_drop = 1'b0; n_addr = '0; n_data = '0;
      end
      @(posedge clk);
      m_we = n_we; m_drop = n_drop; m_addr = n_addr; m_data = n_data;
      #1;
      if (we === 1'b1) wlog.push_back({wr_addr, wr_data});
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; mem_valid = 1'b0;
      alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs();
      cyc();
      n_cmp++;
      if (dut_vec !== mdl_vec) begin
         n_err++; $display("FAIL reset_state: got %h expected %h", dut_vec, mdl_vec);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_cmp++;
         if ({obs_comb, dut_vec} !== {exp_comb, mdl_vec} || {alu_ready, mem_ready} !== 2'b11) begin
            n_err++; $display("FAIL reset_idle[%0d]: got %b/%h expected %b/%h", i, obs_comb, dut_vec, exp_comb, mdl_vec);
         end
      end
   endtask

   task automatic test_alu_single();
      alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if ({obs_comb, dut_vec} !== {exp_comb, mdl_vec}) begin
            n_err++; $display("FAIL alu_single[%0d]: got %b/%h expected %b/%h", i, obs_comb, dut_vec, exp_comb, mdl_vec);
         end
         if (i == 0) begin
            n_cmp++;
            if ({we, wr_addr, wr_data} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
               n_err++; $display("FAIL alu_single_write: got we=%b addr=%0d data=%h expected 1/3/deadbeef", we, wr_addr, wr_data);
            end
         end
         idle_inputs();
      end
   endtask

   task automatic test_fifo_fill();
      wlog.delete();
      alu_valid = 1'b1; alu_addr = 4'd5;
      for (int i = 0; i < 14; i++) begin
         alu_data  = $urandom;
         mem_valid = (i < 4);
         mem_addr  = 4'(i + 1);
         mem_data  = 32'(8'h11 * (i + 1));
         if (i >= 9) alu_valid = 1'b0;
         cyc();
         n_cmp++;
         if ({obs_comb, dut_vec} !== {exp_comb, mdl_vec}) begin
            n_err++; $display("FAIL fifo_fill[%0d]: got %b/%h expected %b/%h", i, obs_comb, dut_vec, exp_comb, mdl_vec);
         end
         if (i == 3) begin
            n_cmp++;
            if ({fifo_count, alu_ready, mem_ready} !== {3'd4, 1'b0, 1'b0}) begin
               n_err++; $display("FAIL fifo_full: got count=%0d alu_ready=%b mem_ready=%b expected 4/0/0", fifo_count, alu_ready, mem_ready);
            end
         end
         if (i == 4) begin
            n_cmp++;
            if ({we, wr_addr, wr_data} !== {1'b1, 4'd1, 32'h11}) begin
               n_err++; $display("FAIL fifo_first_pop: got we=%b addr=%0d data=%h expected 1/1/11", we, wr_addr, wr_data);
            end
         end
      end
      idle_inputs();
      n_cmp++;
      if (wlog.size() < 3 || wlog[wlog.size()-3] !== {4'd2, 32'h22} || wlog[wlog.size()-2] !== {4'd3, 32'h33}
          || wlog[wlog.size()-1] !== {4'd4, 32'h44}) begin
         n_err++; $display("FAIL fifo_drain_order: %0d writes logged, expected loads 2,3,4 last", wlog.size());
      end
   endtask

   task automatic test_drop();
      mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h99;
      for (int i = 0; i < 4; i++) begin
         cyc();
         idle_inputs();
         n_cmp++;
         if ({obs_comb, dut_vec} !== {exp_comb, mdl_vec}) begin
            n_err++; $display("FAIL drop[%0d]: got %b/%h expected %b/%h", i, obs_comb, dut_vec, exp_comb, mdl_vec);
         end
         if (i == 1) begin
            n_cmp++;
            if ({we, drop, fifo_count} !== {1'b0, 1'b1, 3'd0}) begin
               n_err++; $display("FAIL drop_pulse: got we=%b drop=%b count=%0d expected 0/1/0", we, drop, fifo_count);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      alu_valid = 1'b1; alu_addr = 4'd6;
      for (int i = 0; i < 2; i++) begin
         alu_data = $urandom; mem_valid = 1'b1; mem_addr = 4'(i); mem_data = $urandom;
         cyc();
      end
      idle_inputs();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      wlog.delete();
      n_cmp++;
      if ({fifo_count, we, drop} !== 5'b0 || dut_vec !== mdl_vec) begin
         n_err++; $display("FAIL mid_reset: got count=%0d we=%b drop=%b expected 0/0/0", fifo_count, we, drop);
      end
      mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h7;
      for (int i = 0; i < 5; i++) begin
         cyc();
         idle_inputs();
         n_cmp++;
         if ({obs_comb, dut_vec} !== {exp_comb, mdl_vec}) begin
            n_err++; $display("FAIL post_reset[%0d]: got %b/%h expected %b/%h", i, obs_comb, dut_vec, exp_comb, mdl_vec);
         end
      end
      n_cmp++;
      if (wlog.size() != 1 || wlog[0] !== {4'd2, 32'h7}) begin
         n_err++; $display("FAIL post_reset_writes: got %0d writes expected exactly one (2, 7)", wlog.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [35:0] sent[$];
      wlog.delete();
      max_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         mem_valid = (i < 12);
         mem_addr  = 4'($urandom_range(0, NUM_REGS - 1));
         mem_data  = $urandom;
         if (mem_valid && mem_ready) sent.push_back({mem_addr, mem_data});
         cyc();
         n_cmp++;
         if ({obs_comb, dut_vec} !== {exp_comb, mdl_vec}) begin
            n_err++; $display("FAIL wrap[%0d]: got %b/%h expected %b/%h", i, obs_comb, dut_vec, exp_comb, mdl_vec);
         end
      end
      idle_inputs();
      n_cmp++;
      if (sent.size() != 12 || wlog.size() != 12 || max_cnt > DEPTH) begin
         n_err++; $display("FAIL wrap_count: got %0d writes (max count %0d) expected 12 (<= %0d)", wlog.size(), max_cnt, DEPTH);
      end else begin
         for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (wlog[i] !== sent[i]) begin
               n_err++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, wlog[i], sent[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         rst       = ($urandom_range(0, 60) == 0);
         alu_valid = ($urandom_range(0, 2) != 0);
         alu_addr  = 4'($urandom_range(0, 15));
         alu_data  = $urandom;
         mem_valid = ($urandom_range(0, 1) != 0);
         mem_addr  = 4'($urandom_range(0, 15));
         mem_data  = $urandom;
         cyc();
         n_cmp++;
         if ({obs_comb, dut_vec} !== {exp_comb, mdl_vec}) begin
            n_err++; $display("FAIL random[%0d]: got %b/%h expected %b/%h", i, obs_comb, dut_vec, exp_comb, mdl_vec);
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      max_cnt = 0;
      test_reset();
      test_alu_single();
      test_fifo_fill();
      test_drop();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/wb_merge_stage.md
Name: wb_merge_stage

Overview:
- Writeback stage directly upstream of the 3-port register file.
- Merges two result sources onto the file's single write port:
  - ALU results, which complete in one cycle.
  - Memory load responses, which arrive asynchronously and are buffered in a small FIFO.
- Drives the register file's we / wr_addr / wr_data from registers, with exactly one write per cycle at most.

Parameters:
- WIDTH, 32, data width of results and of the register-file write port.
- DEPTH, 4, load-response FIFO entries; power of two, >= 2.
- NUM_REGS, 8, number of physically implemented registers; write addresses >= NUM_REGS are dropped.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle (combinational).
- alu_addr  in  4  destination register of ALU result.
- alu_data  in  WIDTH  ALU result value.
- mem_valid  in  1  load response present.
- mem_ready  out  1  FIFO can accept a load response this cycle (combinational).
- mem_addr  in  4  destination register of load.
- mem_data  in  WIDTH  loaded value.
- we  out  1  register-file write enable (registered).
- wr_addr  out  4  register-file write address (registered).
- wr_data  out  WIDTH  register-file write data (registered).
- drop  out  1  one-cycle pulse: the selected write had address >= NUM_REGS and was suppressed (registered).
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy (registered).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state updates on the rising edge of clk.
- Reset values:
  - we=0, drop=0, wr_addr=0, wr_data=0, fifo_count=0.
  - FIFO read and write pointers = 0.
  - rst asserted mid-operation discards all buffered loads; nothing is written on the cycle after reset.
- Load FIFO:
  - mem_ready = (fifo_count < DEPTH), independent of a same-cycle pop; there is no full pass-through.
  - Push on mem_valid && mem_ready.
  - There is no bypass: an entry pushed in cycle N can be popped no earlier than cycle N+1.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- Arbitration, evaluated each cycle; full = (fifo_count == DEPTH), nonempty = (fifo_count != 0):
  - Case A: full. Pop FIFO head; alu_ready=0.
  - Case B: not full and alu_valid. Accept ALU (alu_ready=1); no pop.
  - Case C: not full, !alu_valid, nonempty. Pop FIFO head.
  - Otherwise: no selection.
  - alu_ready=1 whenever not full, including when alu_valid=0.
- Output register, next cycle after a selection:
  - Selected address < NUM_REGS: we=1, wr_addr=sel_addr, wr_data=sel_data, drop=0.
  - Selected address >= NUM_REGS: we=0, drop=1; wr_addr and wr_data still load the selected values.
  - No selection: we=0, drop=0; wr_addr and wr_data hold their previous values.
- Latency:
  - ALU result accepted in cycle N: we=1 in cycle N+1.
  - Load pushed into an empty FIFO with no ALU traffic: we=1 two cycles after the push.
- Ordering:
  - Loads are written in arrival order.
  - No ordering is enforced between ALU and load writes to the same register; the later-selected write wins in the register file.
- Register 0 is not special; it is written like any other register.

Test Plan:
- Reset then idle: we=0, drop=0, fifo_count=0, alu_ready=1, mem_ready=1 for 10 cycles.
- alu_valid=1, addr=3, data=0xDEADBEEF for one cycle -> next cycle we=1, wr_addr=3, wr_data=0xDEADBEEF; the cycle after, we=0.
- Push loads (addr 1..4, data 0x11..0x44) while alu_valid held high with addr 5 -> alu accepted for 4 cycles, fifo_count reaches 4, mem_ready=0, alu_ready=0.
  - Next cycle: we=1, wr_addr=1, data 0x11.
  - Then ALU resumes while count=3.
  - After alu_valid drops, loads 2,3,4 drain in order.
- Load to addr 9 (NUM_REGS=8) with ALU idle -> two cycles after push: we=0, drop=1 for one cycle, fifo_count returns to 0.
- FIFO holds 2 entries; assert rst for one cycle -> fifo_count=0, we=0 after reset; post-reset load to addr 2, data 0x7 -> only that write appears.
- Wrap-around: 12 back-to-back loads with ALU idle, mem_valid continuous -> 12 writes in order, no loss or duplication, fifo_count never exceeds DEPTH.
